// File: rtl/reg_tablero_pkg.sv
// Shared types for the board register file: cell owner encoding and turn helper.
package tablero_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10,
        RSVD  = 2'b11
    } cell_t;

    function automatic cell_t next_turn(cell_t cur);
        return (cur == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/reg_tablero_if.sv
// Move-request / board-status bundle between the move decoder and the board register file.
interface reg_tablero_if #(
    parameter int unsigned NUM_CELLS = 9,
    parameter int unsigned ADDR_W    = $clog2(NUM_CELLS),
    parameter int unsigned CNT_W     = $clog2(NUM_CELLS + 1)
);
    logic                 clear;
    logic                 write;
    logic [ADDR_W-1:0]    wr_addr;
    logic [1:0]           wr_player;
    logic [ADDR_W-1:0]    rd_addr;
    logic [1:0]           rd_data;
    logic                 wr_ack;
    logic                 wr_reject;
    logic [NUM_CELLS-1:0] p1_mask;
    logic [NUM_CELLS-1:0] p2_mask;
    logic [1:0]           turn;
    logic [CNT_W-1:0]     move_count;
    logic                 full;

    modport master (
        output clear, write, wr_addr, wr_player, rd_addr,
        input  rd_data, wr_ack, wr_reject, p1_mask, p2_mask, turn, move_count, full
    );

    modport slave (
        input  clear, write, wr_addr, wr_player, rd_addr,
        output rd_data, wr_ack, wr_reject, p1_mask, p2_mask, turn, move_count, full
    );
endinterface

// File: rtl/reg_tablero_casilla_cell.sv
// One board cell: owner register with sync clear and load enable, plus decoded owner flags.
module casilla_cell
    import tablero_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  load,
    input  cell_t din,
    output cell_t owner,
    output logic  p1_c,
    output logic  p2_c
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= EMPTY;
        end else if (clear) begin
            owner <= EMPTY;
        end else if (load) begin
            owner <= din;
        end
    end

    assign p1_c = (owner == P1);
    assign p2_c = (owner == P2);
endmodule

// File: rtl/reg_tablero.sv
// Board-state register file enforcing turn order, no-overwrite and range/full rules on moves.
module reg_tablero
    import tablero_pkg::*;
#(
    parameter int unsigned NUM_CELLS    = 9,
    parameter int unsigned ADDR_W       = $clog2(NUM_CELLS),
    parameter int unsigned CNT_W        = $clog2(NUM_CELLS + 1),
    parameter logic [1:0]  FIRST_PLAYER = 2'b01
) (
    input logic          clk,
    input logic          rst,
    reg_tablero_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    cell_t                owner  [NUM_CELLS];
    cell_t                rd_pad [DEPTH];
    logic [NUM_CELLS-1:0] p1_vec;
    logic [NUM_CELLS-1:0] p2_vec;
    logic [NUM_CELLS-1:0] load;
    logic [DEPTH-1:0]     occ_pad;
    cell_t                turn_q;
    logic [CNT_W-1:0]     count_q;
    logic                 ack_q;
    logic                 rej_q;
    logic                 full_c;
    logic                 addr_ok_c;
    logic                 legal_c;

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        casilla_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (bus.clear),
            .load  (load[i]),
            .din   (cell_t'(bus.wr_player)),
            .owner (owner[i]),
            .p1_c  (p1_vec[i]),
            .p2_c  (p2_vec[i])
        );
    end

    // Pad to the full address space so out-of-range addresses read as empty/unoccupied.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) rd_pad[i] = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) rd_pad[i] = owner[i];
    end

    assign occ_pad   = DEPTH'(p1_vec | p2_vec);
    assign full_c    = (count_q == CNT_W'(NUM_CELLS));
    assign addr_ok_c = (32'(bus.wr_addr) < NUM_CELLS);

    // turn_q only ever holds P1/P2, so codes 00 and 11 fail the turn check.
    assign legal_c = bus.write && !bus.clear && addr_ok_c && !occ_pad[bus.wr_addr]
                   && (cell_t'(bus.wr_player) == turn_q) && !full_c;

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            load[i] = legal_c && (bus.wr_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            turn_q  <= cell_t'(FIRST_PLAYER);
            count_q <= '0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else if (bus.clear) begin
            turn_q  <= cell_t'(FIRST_PLAYER);
            count_q <= '0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            ack_q <= legal_c;
            rej_q <= bus.write && !legal_c;
            if (legal_c) begin
                turn_q  <= next_turn(turn_q);
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.rd_data    = 2'(rd_pad[bus.rd_addr]);
    assign bus.wr_ack     = ack_q;
    assign bus.wr_reject  = rej_q;
    assign bus.p1_mask    = p1_vec;
    assign bus.p2_mask    = p2_vec;
    assign bus.turn       = 2'(turn_q);
    assign bus.move_count = count_q;
    assign bus.full       = full_c;
endmodule

// File: tb/tb_reg_tablero.sv
// Directed-vector bench for reg_tablero on the default 3x3 board.
module tb_reg_tablero;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    reg_tablero_if #(.NUM_CELLS(9)) bus ();

    reg_tablero #(.NUM_CELLS(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a move for one edge; returns 1 time unit after that edge.
    task automatic mv(input logic [3:0] addr, input logic [1:0] player);
        bus.write     = 1'b1;
        bus.wr_addr   = addr;
        bus.wr_player = player;
        @(posedge clk);
        #1;
        bus.write = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input logic ack, input logic rej);
        chk({tag, "_ack"}, 32'(bus.wr_ack), 32'(ack));
        chk({tag, "_rej"}, 32'(bus.wr_reject), 32'(rej));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b0;
        bus.clear     = 1'b0;
        bus.write     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_player = '0;
        bus.rd_addr   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle();

        // Reset state
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            #1;
            chk($sformatf("rst_rd%0d", a), 32'(bus.rd_data), 32'd0);
        end
        chk("rst_turn", 32'(bus.turn), 32'd1);
        chk("rst_cnt",  32'(bus.move_count), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_p1",   32'(bus.p1_mask), 32'd0);
        chk("rst_p2",   32'(bus.p2_mask), 32'd0);
        chk_pulse("rst", 1'b0, 1'b0);

        // Two legal moves
        mv(4'd4, 2'b01);
        chk_pulse("mv1", 1'b1, 1'b0);
        mv(4'd0, 2'b10);
        chk_pulse("mv2", 1'b1, 1'b0);
        idle();
        chk_pulse("mv_idle", 1'b0, 1'b0);
        chk("mv_p1",   32'(bus.p1_mask), 32'h010);
        chk("mv_p2",   32'(bus.p2_mask), 32'h001);
        chk("mv_turn", 32'(bus.turn), 32'd1);
        chk("mv_cnt",  32'(bus.move_count), 32'd2);
        bus.rd_addr = 4'd4;
        #1;
        chk("mv_rd4", 32'(bus.rd_data), 32'd1);
        bus.rd_addr = 4'd0;
        #1;
        chk("mv_rd0", 32'(bus.rd_data), 32'd2);

        // Occupied cell, then wrong turn
        mv(4'd4, 2'b01);
        chk_pulse("occ", 1'b0, 1'b1);
        mv(4'd5, 2'b10);
        chk_pulse("wturn", 1'b0, 1'b1);
        // Out-of-range address, reserved code, empty code
        mv(4'd9, 2'b01);
        chk_pulse("oor", 1'b0, 1'b1);
        mv(4'd5, 2'b11);
        chk_pulse("rsvd", 1'b0, 1'b1);
        mv(4'd5, 2'b00);
        chk_pulse("empty", 1'b0, 1'b1);
        idle();
        chk_pulse("rej_idle", 1'b0, 1'b0);
        chk("rej_p1",   32'(bus.p1_mask), 32'h010);
        chk("rej_p2",   32'(bus.p2_mask), 32'h001);
        chk("rej_turn", 32'(bus.turn), 32'd1);
        chk("rej_cnt",  32'(bus.move_count), 32'd2);
        bus.rd_addr = 4'd9;
        #1;
        chk("rd9", 32'(bus.rd_data), 32'd0);

        // Clear, then fill the board with nine alternating moves
        bus.clear = 1'b1;
        idle();
        bus.clear = 1'b0;
        chk("clr_cnt", 32'(bus.move_count), 32'd0);
        for (int i = 0; i < 9; i++) begin
            mv(4'(i), (i % 2 == 0) ? 2'b01 : 2'b10);
            chk_pulse($sformatf("fill%0d", i), 1'b1, 1'b0);
            chk($sformatf("fill%0d_full", i), 32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("full_cnt",  32'(bus.move_count), 32'd9);
        chk("full_p1",   32'(bus.p1_mask), 32'h155);
        chk("full_p2",   32'(bus.p2_mask), 32'h0AA);
        chk("full_turn", 32'(bus.turn), 32'd2);
        mv(4'd3, 2'b10);
        chk_pulse("tenth", 1'b0, 1'b1);
        chk("tenth_cnt", 32'(bus.move_count), 32'd9);

        // Clear wins over a simultaneous write
        bus.clear     = 1'b1;
        bus.write     = 1'b1;
        bus.wr_addr   = 4'd0;
        bus.wr_player = 2'b01;
        idle();
        bus.clear = 1'b0;
        bus.write = 1'b0;
        chk_pulse("clrw", 1'b0, 1'b0);
        chk("clrw_cnt",  32'(bus.move_count), 32'd0);
        chk("clrw_turn", 32'(bus.turn), 32'd1);
        chk("clrw_p1",   32'(bus.p1_mask), 32'd0);
        chk("clrw_p2",   32'(bus.p2_mask), 32'd0);
        chk("clrw_full", 32'(bus.full), 32'd0);
        bus.rd_addr = 4'd0;
        #1;
        chk("clrw_rd0", 32'(bus.rd_data), 32'd0);

        // Asynchronous reset mid-game with an ack pulse outstanding
        mv(4'd3, 2'b01);
        mv(4'd7, 2'b10);
        mv(4'd2, 2'b01);
        chk_pulse("pre_arst", 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk_pulse("arst", 1'b0, 1'b0);
        chk("arst_cnt",  32'(bus.move_count), 32'd0);
        chk("arst_turn", 32'(bus.turn), 32'd1);
        chk("arst_p1",   32'(bus.p1_mask), 32'd0);
        chk("arst_p2",   32'(bus.p2_mask), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        mv(4'd2, 2'b01);
        chk_pulse("resume", 1'b1, 1'b0);
        bus.rd_addr = 4'd2;
        #1;
        chk("resume_rd2",  32'(bus.rd_data), 32'd1);
        chk("resume_cnt",  32'(bus.move_count), 32'd1);
        chk("resume_turn", 32'(bus.turn), 32'd2);
        chk("resume_p1",   32'(bus.p1_mask), 32'h004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
